restoring_divider_16_by_8: RTL and testbench

Sequential unsigned divider: 16-bit dividend by 8-bit divisor, giving a 16-bit quotient and an 8-bit remainder. It uses the restoring algorithm and resolves one quotient bit per clock. It is the inverse companion of the 8-bit Vedic multiplier, so any product the multiplier generates can be divided back by one of its operands. A start/busy/done handshake drives it from the surrounding datapath.

---
 rtl/restoring_divider_16_by_8.sv | 149 ++++++++++++++
 tb/tb_restoring_divider_16_by_8.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_16_by_8.sv
// Sequential unsigned restoring divider, 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Optional macro DIV_ZERO_CHECK_EN: a zero divisor skips iteration and raises div_by_zero with done.
module restoring_divider_16_by_8 #(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // One restoring step. The ninth bit of the partial remainder only exists
  // transiently in the shifted value: after each step R < divisor, so the
  // stored remainder fits WIDTH_D bits and the 8-bit modular difference is exact.
  // Returns {quotient_bit, next_remainder}.
  function automatic logic [WIDTH_D:0] restore_step(
    input logic [WIDTH_D-1:0] r,
    input logic               din,
    input logic [WIDTH_D-1:0] d
  );
    logic [WIDTH_D:0]   sh;
    logic [WIDTH_D-1:0] diff;
    sh   = {r, din};
    diff = sh[WIDTH_D-1:0] - d;
    if (sh >= {1'b0, d}) restore_step = {1'b1, diff};
    else                 restore_step = {1'b0, sh[WIDTH_D-1:0]};
  endfunction

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH_N-1:0] quotient_q;
  logic [WIDTH_D-1:0] remainder_q;

  logic [WIDTH_N-1:0] dvd_q;
  logic [WIDTH_D-1:0] dvs_q;
  logic [WIDTH_D-1:0] r_q;
  logic [WIDTH_N-1:0] q_q;

  logic [WIDTH_D:0]   step_d;
  logic               qbit_d;
  logic [WIDTH_D-1:0] r_d;
  logic               accept;

  assign step_d = restore_step(r_q, dvd_q[WIDTH_N-1], dvs_q);
  assign qbit_d = step_d[WIDTH_D];
  assign r_d    = step_d[WIDTH_D-1:0];
  assign accept = (state_q == IDLE) && start;

`ifdef DIV_ZERO_CHECK_EN
  logic dbz_q;
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  // Control FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_ZERO_CHECK_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            cnt_q <= '0;
`ifdef DIV_ZERO_CHECK_EN
            if (divisor == '0) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              dbz_q       <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend[WIDTH_D-1:0];
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              dbz_q   <= 1'b0;
            end
`else
            state_q <= RUN;
            busy_q  <= 1'b1;
`endif
          end
        end
        RUN: begin
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= {q_q[WIDTH_N-2:0], qbit_d};
            remainder_q <= r_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Iteration datapath; the dividend register shifts left so its MSB is always dividend[15-count]
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_q <= dividend;
      dvs_q <= divisor;
      r_q   <= '0;
      q_q   <= '0;
    end else if (state_q == RUN) begin
      dvd_q <= {dvd_q[WIDTH_N-2:0], 1'b0};
      r_q   <= r_d;
      q_q   <= {q_q[WIDTH_N-2:0], qbit_d};
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_restoring_divider_16_by_8.sv
// Scoreboard bench for restoring_divider_16_by_8: directed vectors push expectations,
// a negedge monitor pops and checks them on every done pulse.
module tb_restoring_divider_16_by_8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  restoring_divider_16_by_8 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

`ifdef DIV_ZERO_CHECK_EN
  localparam int   ZLAT = 1;
  localparam int   ZBSY = 0;
  localparam logic ZDBZ = 1'b1;
`else
  localparam int   ZLAT = 17;
  localparam int   ZBSY = 16;
  localparam logic ZDBZ = 1'b0;
`endif

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat;
    int          bsy;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: checks every done pulse against the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_run = 0;
      end else begin
        if (busy) busy_run++;
        if (done) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 q=%0d r=%0d, expected no done", quotient, remainder);
          end else begin
            e = sb.pop_front();
            chk("quotient",    32'(quotient),    32'(e.q));
            chk("remainder",   32'(remainder),   32'(e.r));
            chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            chk("latency",     32'(cyc - e.acc), 32'(e.lat));
            chk("busy_cycles", 32'(busy_run),    32'(e.bsy));
          end
          busy_run = 0;
        end
      end
    end
  end

  function automatic exp_t mk(input logic [15:0] q, input logic [7:0] r, input logic dbz,
                              input int lat, input int bsy, input int acc);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.lat = lat; e.bsy = bsy; e.acc = acc;
    return e;
  endfunction

  // Presents one operation for a single accepting edge; DUT must be idle.
  task automatic issue(input logic [15:0] a, input logic [7:0] b, input bit push,
                       input logic [15:0] eq, input logic [7:0] er, input logic edbz,
                       input int elat, input int ebsy);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    if (push) sb.push_back(mk(eq, er, edbz, elat, ebsy, cyc));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done in 60 cycles, expected done", name);
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = 16'd0; divisor = 8'd0;

    // Reset with a start pulse applied: nothing may begin
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 16'd196; divisor = 8'd14;
    repeat (2) @(negedge clk);
    chk("rst_busy",      32'(busy),        32'd0);
    chk("rst_done",      32'(done),        32'd0);
    chk("rst_quotient",  32'(quotient),    32'd0);
    chk("rst_remainder", 32'(remainder),   32'd0);
    chk("rst_dbz",       32'(div_by_zero), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    issue(16'd196, 8'd14, 1'b1, 16'd14, 8'd0, 1'b0, 17, 16);
    chk("busy_after_e0", 32'(busy), 32'd1);
    wait_done("196_14");
    issue(16'd26115, 8'd192, 1'b1, 16'd136,   8'd3, 1'b0, 17, 16); wait_done("26115_192");
    issue(16'd65535, 8'd1,   1'b1, 16'd65535, 8'd0, 1'b0, 17, 16); wait_done("65535_1");
    issue(16'd65535, 8'd255, 1'b1, 16'd257,   8'd0, 1'b0, 17, 16); wait_done("65535_255");
    issue(16'd5,     8'd200, 1'b1, 16'd0,     8'd5, 1'b0, 17, 16); wait_done("5_200");

    // Start re-pulsed with other operands around count 7 must be ignored
    issue(16'd1000, 8'd7, 1'b1, 16'd142, 8'd6, 1'b0, 17, 16);
    repeat (6) @(negedge clk);
    start = 1'b1; dividend = 16'd40000; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("1000_7");
    repeat (20) @(negedge clk);

    // Reset around count 10 abandons the operation with no done
    issue(16'd5000, 8'd3, 1'b0, 16'd0, 8'd0, 1'b0, 0, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",      32'(busy),      32'd0);
    chk("midrst_done",      32'(done),      32'd0);
    chk("midrst_quotient",  32'(quotient),  32'd0);
    chk("midrst_remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    issue(16'd300, 8'd17, 1'b1, 16'd17, 8'd11, 1'b0, 17, 16); wait_done("300_17");

    // Zero divisor
    issue(16'd1000, 8'd0, 1'b1, 16'hFFFF, 8'd232, ZDBZ, ZLAT, ZBSY); wait_done("1000_0");
    issue(16'd196, 8'd14, 1'b1, 16'd14, 8'd0, 1'b0, 17, 16);         wait_done("dbz_clear");

    // Back-to-back: start held through DONE is accepted 18 cycles after the first
    @(negedge clk);
    start = 1'b1; dividend = 16'd26115; divisor = 8'd192;
    sb.push_back(mk(16'd136, 8'd3, 1'b0, 17, 16, cyc));
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      if (!seen) begin
        n_cmp++;
        n_err++;
        $display("FAIL b2b_timeout: got no done in 60 cycles, expected done");
      end
    end
    dividend = 16'd65535; divisor = 8'd255;
    sb.push_back(mk(16'd257, 8'd0, 1'b0, 17, 16, cyc + 1));
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done("b2b_second");

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
